// File: rtl/spi_master_tx.sv
// Byte-stream SPI mode-0 transmitter: one-entry holding register feeding an 8-bit shift register.
// All pin outputs come from flops; frames span bytes until a byte tagged last, then CS idles >= CS_GAP.
module spi_master_tx #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       clk_in,
  input  logic       spi_rst_n,
  input  logic       byte_valid_in,
  input  logic [7:0] byte_data_in,
  input  logic       byte_last_in,
  output logic       byte_ready_out,
  output logic       spi_sclk_out,
  output logic       spi_mosi_out,
  output logic       spi_cs_n_out,
  output logic       busy_out
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, STALL, HOLD, GAP} state_e;

  localparam logic [7:0] DIV_TERM = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_TERM = 8'(CS_GAP - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q, shift_d;
  logic       last_q;
  logic       sclk_q, mosi_q, cs_n_q, busy_q;

  logic       hold_vld_q, hold_vld_d;
  logic       hold_last_q, hold_last_d;
  logic [7:0] hold_dat_q, hold_dat_d;

  logic accept, div_tick, fall, byte_end, load;

  assign accept   = byte_valid_in && !hold_vld_q;
  assign div_tick = (cnt_q == DIV_TERM);
  assign fall     = (state_q == SHIFT) && div_tick && sclk_q;
  assign byte_end = fall && (bit_q == 3'd7);
  // The holding byte moves into the shifter from IDLE, STALL, or seamlessly at a non-final byte end.
  assign load     = hold_vld_q && ((state_q == IDLE) || (state_q == STALL) || (byte_end && !last_q));

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_dat_d  = hold_dat_q;
    hold_last_d = hold_last_q;
    if (load) begin
      hold_vld_d = 1'b0;
    end else if (accept) begin
      hold_vld_d  = 1'b1;
      hold_dat_d  = byte_data_in;
      hold_last_d = byte_last_in;
    end
  end

  always_comb begin
    shift_d = shift_q;
    if (load) begin
      shift_d = hold_dat_q;
    end else if (fall && !byte_end) begin
      shift_d = shift_q << 1;
    end
  end

  always_ff @(posedge clk_in or negedge spi_rst_n) begin
    if (!spi_rst_n) begin
      hold_vld_q  <= 1'b0;
      hold_dat_q  <= 8'd0;
      hold_last_q <= 1'b0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_dat_q  <= hold_dat_d;
      hold_last_q <= hold_last_d;
    end
  end

  always_ff @(posedge clk_in or negedge spi_rst_n) begin
    if (!spi_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      last_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      if (load) begin
        last_q <= hold_last_q;
      end
      if (load || (fall && !byte_end)) begin
        mosi_q <= shift_d[7];
      end
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= SETUP;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= 8'd0;
            bit_q   <= 3'd0;
          end
        end
        SETUP: begin
          if (div_tick) begin
            cnt_q   <= 8'd0;
            sclk_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SHIFT: begin
          if (div_tick) begin
            cnt_q  <= 8'd0;
            sclk_q <= ~sclk_q;
            if (sclk_q) begin
              bit_q <= bit_q + 3'd1;
              if (byte_end) begin
                if (last_q) begin
                  state_q <= HOLD;
                end else if (!hold_vld_q) begin
                  state_q <= STALL;
                end
              end
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        STALL: begin
          if (load) begin
            state_q <= SETUP;
            cnt_q   <= 8'd0;
          end
        end
        HOLD: begin
          if (div_tick) begin
            cnt_q   <= 8'd0;
            state_q <= GAP;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_TERM) begin
            cnt_q   <= 8'd0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready_out = ~hold_vld_q;
  assign spi_sclk_out   = sclk_q;
  assign spi_mosi_out   = mosi_q;
  assign spi_cs_n_out   = cs_n_q;
  assign busy_out       = busy_q;

endmodule
